// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_wb_arbiter: round-robin writeback arbiter for two register-file       |
// | writers, registered output stage with x0 write suppression.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_waddr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_waddr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0]  c_cnt_max = '1;
  localparam logic [ADDR_W-1:0] c_zero_a  = '0;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_xfer;
  logic              w_both;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    w_both     = m0_valid & m1_valid;
    w_grant0   = ~rst & m0_valid & (~m1_valid | r_last_grant);
    w_grant1   = ~rst & m1_valid & (~m0_valid | ~r_last_grant);
    w_xfer     = w_grant0 | w_grant1;
    w_sel_addr = w_grant1 ? m1_waddr : m0_waddr;
    w_sel_data = w_grant1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we           <= 1'b0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_last_grant   <= 1'b1;
      r_conflict_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_we         <= (w_sel_addr != c_zero_a);
        r_waddr      <= w_sel_addr;
        r_wdata      <= w_sel_data;
        r_last_grant <= w_grant1;
      end else begin
        r_we         <= 1'b0;
      end
      if (w_both && (r_conflict_cnt != c_cnt_max))
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign m0_ready     = w_grant0;
  assign m1_ready     = w_grant1;
  assign rf_we        = r_we;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign last_grant   = r_last_grant;
  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire
